mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single byte-wide RAM port in the RISC-V core. Accepts word fetches from the IF stage and 1/2/4-byte loads/stores from the MEM stage. Grants the port to one requester at a time (MEM over IF) and issues the per-byte address/write strobes. For loads and fetches, it assembles the returned bytes little-endian and pulses a per-requester `done` with the data.

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_byte_assembler.sv | 68 ++++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide RAM port sequencer.
// Holds the FSM state encoding, the mem_len codes, the owner constants and
// a helper that turns a mem_len code into a byte count.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_TAIL   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [1:0] LEN_B = 2'd0;
   localparam logic [1:0] LEN_H = 2'd1;
   localparam logic [1:0] LEN_W = 2'd2;

   localparam logic OWNER_IF  = 1'b0;
   localparam logic OWNER_MEM = 1'b1;

   // Byte counter must hold 0..4 (it steps once past the last byte).
   localparam int BYTE_CNT_W = 3;

   // Code 3 is not a legal size; it is handled as a full word.
   function automatic logic [BYTE_CNT_W-1:0] len_to_bytes(input logic [1:0] len);
      case (len)
         LEN_B:   return BYTE_CNT_W'(1);
         LEN_H:   return BYTE_CNT_W'(2);
         default: return BYTE_CNT_W'(4);
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Byte-lane datapath for the RAM port sequencer.
// Keeps the byte index k, selects the store byte for lane k, and inserts
// returned read bytes into their little-endian lane.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (byte counter only)
//   start_i     : new transaction accepted; k=0, latch wdata, clear read data
//   step_i      : advance k by one
//   cap_en_i    : write din_i into lane k-1
//   wdata_i     : store data to latch on start_i
//   din_i       : byte returned by the RAM
//   k_o         : current byte index
//   wbyte_o     : store byte for lane k
//   rdata_o     : assembled read data (unused lanes stay zero)
module mem_byte_assembler
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  step_i,
   input  logic                  cap_en_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [7:0]            din_i,
   output logic [BYTE_CNT_W-1:0] k_o,
   output logic [7:0]            wbyte_o,
   output logic [DATA_W-1:0]     rdata_o
);

   logic [BYTE_CNT_W-1:0] k_q, k_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic [1:0]            cap_lane;

   // Read data lags the issued address by one cycle, so the byte
   // arriving now belongs to the lane issued one step earlier.
   assign cap_lane = 2'(k_q - BYTE_CNT_W'(1));

   always_comb begin
      k_d     = k_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      if (start_i) begin
         k_d     = '0;
         wdata_d = wdata_i;
         data_d  = '0;
      end else begin
         if (step_i)   k_d = k_q + BYTE_CNT_W'(1);
         if (cap_en_i) data_d[8*cap_lane +: 8] = din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) k_q <= '0;
      else     k_q <= k_d;
   end

   always_ff @(posedge clk) begin
      wdata_q <= wdata_d;
      data_q  <= data_d;
   end

   assign k_o     = k_q;
   assign wbyte_o = wdata_q[8*k_q[1:0] +: 8];
   assign rdata_o = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single byte-wide RAM port.
// Serves word fetches from IF and 1/2/4-byte loads/stores from MEM, one at a
// time with MEM having fixed priority, walks the bytes of the access on the
// RAM port and returns assembled little-endian read data with a done pulse.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req/if_addr                   : IF fetch request (level) and address
//   if_busy/if_done/if_data          : IF pending flag, done pulse, word
//   mem_req/mem_wr/mem_len/mem_addr  : MEM request, store flag, size, address
//   mem_wdata                        : MEM store data (low bytes used)
//   mem_busy/mem_done/mem_rdata      : MEM pending flag, done pulse, load data
//   ram_a/ram_dout/ram_wr            : RAM byte address, write byte, strobe
//   ram_din                          : RAM read byte, one cycle after ram_a
module mem_port_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_busy,
   output logic              if_done,
   output logic [DATA_W-1:0] if_data,
   input  logic              mem_req,
   input  logic              mem_wr,
   input  logic [1:0]        mem_len,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_busy,
   output logic              mem_done,
   output logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] ram_a,
   output logic [7:0]        ram_dout,
   output logic              ram_wr,
   input  logic [7:0]        ram_din
);

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [BYTE_CNT_W-1:0] n_q, n_d;
   logic                  wr_q, wr_d;
   logic                  if_busy_q, if_busy_d;
   logic                  mem_busy_q, mem_busy_d;
   logic                  if_done_q, if_done_d;
   logic                  mem_done_q, mem_done_d;

   logic                  start, step, cap_en;
   logic [BYTE_CNT_W-1:0] k;
   logic [7:0]            wbyte;
   logic [DATA_W-1:0]     rdata;

   mem_byte_assembler #(
      .DATA_W (DATA_W)
   ) u_asm (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start),
      .step_i   (step),
      .cap_en_i (cap_en),
      .wdata_i  (mem_wdata),
      .din_i    (ram_din),
      .k_o      (k),
      .wbyte_o  (wbyte),
      .rdata_o  (rdata)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      base_d     = base_q;
      n_d        = n_q;
      wr_d       = wr_q;
      start      = 1'b0;
      step       = 1'b0;
      cap_en     = 1'b0;
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      ram_a      = '0;
      ram_dout   = 8'h00;
      ram_wr     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_req) begin
               start   = 1'b1;
               owner_d = OWNER_MEM;
               base_d  = mem_addr;
               n_d     = len_to_bytes(mem_len);
               wr_d    = mem_wr;
               state_d = ST_ACCESS;
            end else if (if_req) begin
               start   = 1'b1;
               owner_d = OWNER_IF;
               base_d  = if_addr;
               n_d     = BYTE_CNT_W'(4);
               wr_d    = 1'b0;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // Address arithmetic wraps naturally at ADDR_W bits.
            ram_a    = base_q + ADDR_W'(k);
            ram_wr   = wr_q;
            ram_dout = wr_q ? wbyte : 8'h00;
            step     = 1'b1;
            // Byte k-1 is on ram_din now; byte 0 has not arrived yet at k=0.
            cap_en   = ~wr_q & (k != '0);
            if (k == n_q - BYTE_CNT_W'(1)) state_d = wr_q ? ST_DONE : ST_TAIL;
         end
         ST_TAIL: begin
            cap_en  = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if_done_d  = (owner_q == OWNER_IF);
            mem_done_d = (owner_q == OWNER_MEM);
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if_busy_d  = if_req  & ~((state_q == ST_DONE) & (owner_q == OWNER_IF));
      mem_busy_d = mem_req & ~((state_q == ST_DONE) & (owner_q == OWNER_MEM));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWNER_IF;
         n_q        <= '0;
         wr_q       <= 1'b0;
         if_busy_q  <= 1'b0;
         mem_busy_q <= 1'b0;
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         n_q        <= n_d;
         wr_q       <= wr_d;
         if_busy_q  <= if_busy_d;
         mem_busy_q <= mem_busy_d;
         if_done_q  <= if_done_d;
         mem_done_q <= mem_done_d;
      end
   end

   // Base address is only observed while ACCESS is active.
   always_ff @(posedge clk) begin
      base_q <= base_d;
   end

   // The assembled word is held until the next accept, which cannot occur
   // before the done cycle has ended, so gating by done keeps it stable.
   assign if_busy   = if_busy_q;
   assign mem_busy  = mem_busy_q;
   assign if_done   = if_done_q;
   assign mem_done  = mem_done_q;
   assign if_data   = if_done_q  ? rdata : '0;
   assign mem_rdata = mem_done_q ? rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_busy, if_done;
   logic [31:0] if_data;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_len;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_busy, mem_done;
   logic [31:0] mem_rdata;
   logic [31:0] ram_a;
   logic [7:0]  ram_dout;
   logic        ram_wr;
   logic [7:0]  ram_din;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_busy   (if_busy),
      .if_done   (if_done),
      .if_data   (if_data),
      .mem_req   (mem_req),
      .mem_wr    (mem_wr),
      .mem_len   (mem_len),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_busy  (mem_busy),
      .mem_done  (mem_done),
      .mem_rdata (mem_rdata),
      .ram_a     (ram_a),
      .ram_dout  (ram_dout),
      .ram_wr    (ram_wr),
      .ram_din   (ram_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment RAM (driven by the DUT bus) and the expected memory image
   // (updated from transaction descriptions only).
   logic [7:0] ram_mem   [logic [31:0]];
   logic [7:0] model_mem [logic [31:0]];

   function automatic logic [7:0] def_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (ram_mem.exists(a)) return ram_mem[a];
      return def_byte(a);
   endfunction

   function automatic logic [7:0] model_rd(input logic [31:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      return def_byte(a);
   endfunction

   bit [31:0] s_a  = '0;
   bit        s_wr = 1'b0;
   bit [7:0]  s_d  = '0;

   always @(negedge clk) begin
      s_a  = ram_a;
      s_wr = ram_wr;
      s_d  = ram_dout;
   end

   always @(posedge clk) begin
      if (s_wr) ram_mem[s_a] = s_d;
      ram_din <= ram_rd(s_a);
   end

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      ram_mem[a]   = b;
      model_mem[a] = b;
   endtask

   // Issues one transaction starting right before its accept edge and checks
   // every cycle up to and including the done pulse; the request is dropped
   // in the done cycle.
   task automatic run_txn(input bit is_mem, input bit wr, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit other_held, input string tag,
                          output logic [31:0] got);
      int n, lat;
      logic [31:0] exp_data, exp_a;
      logic own_done, oth_done, own_busy, oth_busy;
      logic [31:0] own_data;
      n = !is_mem ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
      if (!is_mem) wr = 1'b0;
      exp_data = '0;
      for (int k = 0; k < n; k++) begin
         exp_a = addr + 32'(k);
         if (wr) model_mem[exp_a] = wdata[8*k +: 8];
         else    exp_data[8*k +: 8] = model_rd(exp_a);
      end
      if (is_mem) begin
         mem_req = 1'b1; mem_wr = wr; mem_len = len; mem_addr = addr; mem_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      lat = wr ? n + 1 : n + 2;
      got = '0;
      for (int e = 0; e <= lat; e++) begin
         @(posedge clk); #1;
         own_done = is_mem ? mem_done : if_done;
         oth_done = is_mem ? if_done : mem_done;
         own_busy = is_mem ? mem_busy : if_busy;
         oth_busy = is_mem ? if_busy : mem_busy;
         own_data = is_mem ? mem_rdata : if_data;
         if (e < n) begin
            exp_a = addr + 32'(e);
            checks++;
            if (ram_a !== exp_a) begin
               errors++;
               $display("FAIL %s ram_a byte%0d: got %h expected %h", tag, e, ram_a, exp_a);
            end
            checks++;
            if (ram_wr !== wr) begin
               errors++;
               $display("FAIL %s ram_wr byte%0d: got %b expected %b", tag, e, ram_wr, wr);
            end
            if (wr) begin
               checks++;
               if (ram_dout !== wdata[8*e +: 8]) begin
                  errors++;
                  $display("FAIL %s ram_dout byte%0d: got %h expected %h", tag, e, ram_dout, wdata[8*e +: 8]);
               end
            end
         end else begin
            checks++;
            if (ram_wr !== 1'b0) begin
               errors++;
               $display("FAIL %s ram_wr after bytes cyc%0d: got %b expected 0", tag, e, ram_wr);
            end
         end
         if (e < lat) begin
            checks++;
            if (own_done !== 1'b0 || own_busy !== 1'b1) begin
               errors++;
               $display("FAIL %s done/busy cyc%0d: got %b/%b expected 0/1", tag, e, own_done, own_busy);
            end
         end else begin
            got = own_data;
            checks++;
            if (own_done !== 1'b1 || own_busy !== 1'b0) begin
               errors++;
               $display("FAIL %s done/busy at done: got %b/%b expected 1/0", tag, own_done, own_busy);
            end
            if (!wr) begin
               checks++;
               if (own_data !== exp_data) begin
                  errors++;
                  $display("FAIL %s read data: got %h expected %h", tag, own_data, exp_data);
               end
            end
         end
         checks++;
         if (oth_done !== 1'b0 || (other_held && oth_busy !== 1'b1)) begin
            errors++;
            $display("FAIL %s other requester cyc%0d: got done=%b busy=%b expected done=0 busy=%b",
                     tag, e, oth_done, oth_busy, other_held);
         end
      end
      if (is_mem) mem_req = 1'b0;
      else        if_req  = 1'b0;
   endtask

   task automatic idle_cycles(input int n, input string tag);
      repeat (n) begin
         @(posedge clk); #1;
         checks++;
         if ({ram_wr, ram_a, ram_dout, if_done, mem_done} !== '0) begin
            errors++;
            $display("FAIL %s idle: got wr=%b a=%h dout=%h if_done=%b mem_done=%b expected all 0",
                     tag, ram_wr, ram_a, ram_dout, if_done, mem_done);
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] got;
      rst = 1'b1; if_req = 1'b1; if_addr = 32'h0000_3000;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if ({if_busy, if_done, if_data, mem_busy, mem_done, mem_rdata, ram_a, ram_dout, ram_wr} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got if=%b%b%h mem=%b%b%h ram=%h/%h/%b expected all 0",
                     if_busy, if_done, if_data, mem_busy, mem_done, mem_rdata, ram_a, ram_dout, ram_wr);
         end
      end
      rst = 1'b0;
      run_txn(1'b0, 1'b0, 2'd2, 32'h0000_3000, 32'h0, 1'b0, "reset_release", got);
      idle_cycles(1, "reset_release");
   endtask

   task automatic test_if_fetch();
      logic [31:0] got;
      preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
      preload(32'h1002, 8'h10); preload(32'h1003, 8'h00);
      run_txn(1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b0, "if_fetch", got);
      checks++;
      if (got !== 32'h0010_0513) begin
         errors++;
         $display("FAIL if_fetch word: got %h expected 00100513", got);
      end
      idle_cycles(1, "if_fetch");
   endtask

   task automatic test_store_half();
      logic [31:0] got;
      run_txn(1'b1, 1'b1, 2'd1, 32'h0000_2002, 32'hDEAD_BEEF, 1'b0, "store_half", got);
      idle_cycles(1, "store_half");
      checks++;
      if (ram_rd(32'h2002) !== 8'hEF || ram_rd(32'h2003) !== 8'hBE ||
          ram_mem.exists(32'h2001) || ram_mem.exists(32'h2004)) begin
         errors++;
         $display("FAIL store_half ram image: got %h %h expected ef be, neighbours untouched",
                  ram_rd(32'h2002), ram_rd(32'h2003));
      end
   endtask

   task automatic test_priority();
      logic [31:0] got_mem, got_if;
      preload(32'h10, 8'h80);
      if_req = 1'b1; if_addr = 32'h0000_1000;
      run_txn(1'b1, 1'b0, 2'd0, 32'h0000_0010, 32'h0, 1'b1, "prio_mem", got_mem);
      run_txn(1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b0, "prio_if", got_if);
      checks++;
      if (got_mem !== 32'h0000_0080 || got_if !== 32'h0010_0513) begin
         errors++;
         $display("FAIL priority data: got mem=%h if=%h expected 00000080 00100513", got_mem, got_if);
      end
      idle_cycles(1, "priority");
   endtask

   task automatic test_wrap();
      logic [31:0] got;
      run_txn(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 1'b0, "wrap_load", got);
      idle_cycles(1, "wrap_load");
   endtask

   task automatic test_reset_mid();
      logic [31:0] got;
      mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'd2;
      mem_addr = 32'h0000_4000; mem_wdata = 32'h1122_3344;
      for (int e = 0; e < 3; e++) begin
         @(posedge clk); #1;
         checks++;
         if (ram_a !== 32'h4000 + 32'(e) || ram_wr !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid byte%0d: got a=%h wr=%b expected %h/1", e, ram_a, ram_wr, 32'h4000 + 32'(e));
         end
      end
      // Bytes 0..2 had their strobe high for a full cycle.
      model_mem[32'h4000] = 8'h44; model_mem[32'h4001] = 8'h33; model_mem[32'h4002] = 8'h22;
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         mem_req = 1'b0;
         checks++;
         if (ram_wr !== 1'b0 || mem_done !== 1'b0 || mem_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid in reset cyc%0d: got wr=%b done=%b busy=%b expected 0/0/0",
                     c, ram_wr, mem_done, mem_busy);
         end
      end
      rst = 1'b0;
      idle_cycles(3, "reset_mid_after");
      run_txn(1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'h0, 1'b0, "reset_mid_reload", got);
      idle_cycles(1, "reset_mid_reload");
   endtask

   task automatic test_random();
      logic [31:0] got, addr;
      bit is_mem, wr;
      logic [1:0] len;
      for (int i = 0; i < 40; i++) begin
         is_mem = ($urandom_range(0, 3) != 0);
         wr     = $urandom_range(0, 1);
         len    = 2'($urandom_range(0, 3));
         addr   = ($urandom_range(0, 2) != 0 ? 32'h0000_8000 : 32'hFFFF_FFF0) + 32'($urandom_range(0, 15));
         run_txn(is_mem, wr, len, addr, $urandom, 1'b0, "random", got);
         idle_cycles($urandom_range(1, 3), "random");
      end
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_wr = 1'b0; mem_len = '0; mem_addr = '0; mem_wdata = '0;
      #1;
      test_reset();
      test_if_fetch();
      test_store_half();
      test_priority();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
